tile_spawn_ctrl: RTL and testbench

//  Sequences new-tile spawning for the 2048 board after each move.

---
 rtl/tile_spawn_pkg.sv | 16 +
 rtl/tile_spawn_ctrl.sv | 99 +++++++++
 tb/tb_tile_spawn_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tile_spawn_pkg.sv
// Shared types and constants for the 2048 tile spawn controller.
package tile_spawn_pkg;

  localparam int IDX_W   = 4;
  localparam int N_CELLS = 2 ** IDX_W;

  localparam logic [1:0] VAL_TWO  = 2'd1;
  localparam logic [1:0] VAL_FOUR = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    PRESENT = 2'd2
  } state_t;

endpackage

// File: rtl/tile_spawn_ctrl.sv
// Picks a random empty board cell after each move and hands index/value to the board
// update logic over a valid/ready handshake.
//
// state   | meaning
// IDLE    | waiting for spawn_req; refuses with board_full when no cell is empty
// SCAN    | walking the occupancy snapshot from the random start cell, with wrap
// PRESENT | spawn_valid high, cell/value held until spawn_ready
module tile_spawn_ctrl
  import tile_spawn_pkg::*;
#(
  parameter int FOUR_THRESH = 2
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [IDX_W-1:0] rand_in,
  input  logic             spawn_req,
  input  logic [N_CELLS-1:0] occupied,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [IDX_W-1:0] spawn_cell,
  output logic [1:0]       spawn_value,
  output logic             board_full,
  output logic             busy
);

  localparam logic [IDX_W-1:0] FOUR_T = IDX_W'(FOUR_THRESH);

  state_t state, state_nxt;

  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   offset;
  logic [N_CELLS-1:0] occ_snap;
  logic [IDX_W-1:0]   scan_idx;
  logic               cell_free;
  logic               all_full;
  logic               accept;

  // 4-bit addition gives the mod-16 wrap for free
  assign scan_idx  = start + offset;
  assign cell_free = ~occ_snap[scan_idx];
  assign all_full  = &occupied;
  assign accept    = (state == IDLE) && spawn_req && !all_full;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)      state_nxt = SCAN;
      SCAN:    if (cell_free)   state_nxt = PRESENT;
      PRESENT: if (spawn_ready) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spawn_valid = (state == PRESENT);
    busy        = (state != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      start       <= '0;
      offset      <= '0;
      occ_snap    <= '0;
      spawn_cell  <= '0;
      spawn_value <= '0;
      board_full  <= 1'b0;
    end else begin
      board_full <= (state == IDLE) && spawn_req && all_full;
      case (state)
        IDLE: begin
          if (accept) begin
            start    <= rand_in;
            occ_snap <= occupied;
            offset   <= '0;
          end
        end
        SCAN: begin
          // value uses a fresh counter sample so it is decorrelated from the cell
          if (cell_free) begin
            spawn_cell  <= scan_idx;
            spawn_value <= (rand_in < FOUR_T) ? VAL_FOUR : VAL_TWO;
          end else begin
            offset <= offset + 1'b1;
          end
        end
        PRESENT: begin
          if (spawn_ready) spawn_value <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_spawn_ctrl.sv
// Directed-vector bench for tile_spawn_ctrl with hand-computed expectations.
module tb_tile_spawn_ctrl;

  logic        CLOCK_50 = 1'b0;
  logic        reset;
  logic [3:0]  rand_in;
  logic        spawn_req;
  logic [15:0] occupied;
  logic        spawn_valid;
  logic        spawn_ready;
  logic [3:0]  spawn_cell;
  logic [1:0]  spawn_value;
  logic        board_full;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int lat;

  tile_spawn_ctrl dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .rand_in     (rand_in),
    .spawn_req   (spawn_req),
    .occupied    (occupied),
    .spawn_valid (spawn_valid),
    .spawn_ready (spawn_ready),
    .spawn_cell  (spawn_cell),
    .spawn_value (spawn_value),
    .board_full  (board_full),
    .busy        (busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Issues one request; lat counts edges from the sampling edge (=1) until valid is seen.
  task automatic spawn(input logic [15:0] occ, input logic [3:0] r_req,
                       input logic [3:0] r_exit, output int n);
    occupied  = occ;
    rand_in   = r_req;
    spawn_req = 1'b1;
    tick();
    n = 1;
    spawn_req = 1'b0;
    rand_in   = r_exit;
    while (!spawn_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic handshake(input logic [3:0] exp_cell);
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    check("hs_valid", spawn_valid, 0);
    check("hs_value", spawn_value, 0);
    check("hs_cell",  spawn_cell,  exp_cell);
    check("hs_busy",  busy,        0);
  endtask

  initial begin
    reset       = 1'b1;
    rand_in     = 4'd0;
    spawn_req   = 1'b0;
    occupied    = 16'h0000;
    spawn_ready = 1'b0;
    #3;
    check("rst_valid", spawn_valid, 0);
    check("rst_cell",  spawn_cell,  0);
    check("rst_value", spawn_value, 0);
    check("rst_full",  board_full,  0);
    check("rst_busy",  busy,        0);
    #4 reset = 1'b0;
    tick();

    // empty board, start 5, value sample 9 -> tile 2, minimum latency
    spawn(16'h0000, 4'd5, 4'd9, lat);
    check("t2_lat",   lat,         2);
    check("t2_cell",  spawn_cell,  5);
    check("t2_value", spawn_value, 1);
    check("t2_busy",  busy,        1);
    handshake(4'd5);

    // only cell 0 free, start 1 -> full wrap, maximum latency
    spawn(16'hFFFE, 4'd1, 4'd0, lat);
    check("t3_lat",   lat,         17);
    check("t3_cell",  spawn_cell,  0);
    check("t3_value", spawn_value, 2);
    handshake(4'd0);

    // start 14, cells 14,15,0 taken -> cell 1 at k=3
    spawn(16'hC001, 4'd14, 4'd7, lat);
    check("wrap_lat",  lat,        5);
    check("wrap_cell", spawn_cell, 1);
    handshake(4'd1);

    // full board refusal
    occupied  = 16'hFFFF;
    spawn_req = 1'b1;
    tick();
    spawn_req = 1'b0;
    check("t4_full_hi", board_full, 1);
    check("t4_busy",    busy,       0);
    check("t4_valid",   spawn_valid, 0);
    tick();
    check("t4_full_lo", board_full, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_novalid", spawn_valid, 0);
    end

    // hold in PRESENT; inputs churn, second req must be ignored
    spawn(16'h00F0, 4'd4, 4'd1, lat);
    check("t5_lat",  lat,        6);
    check("t5_cell", spawn_cell, 8);
    for (int i = 0; i < 10; i++) begin
      occupied  = ~occupied;
      rand_in   = 4'(i);
      spawn_req = (i == 3);
      tick();
      check("t5_hold_valid", spawn_valid, 1);
      check("t5_hold_cell",  spawn_cell,  8);
      check("t5_hold_value", spawn_value, 2);
    end
    spawn_req = 1'b0;
    handshake(4'd8);
    tick();
    check("t5_noqueue_busy",  busy,        0);
    check("t5_noqueue_valid", spawn_valid, 0);

    // threshold boundary on the value sample
    spawn(16'h0000, 4'd3, 4'd1, lat);
    check("t6a_value", spawn_value, 2);
    check("t6a_cell",  spawn_cell,  3);
    handshake(4'd3);
    spawn(16'h0000, 4'd3, 4'd2, lat);
    check("t6b_value", spawn_value, 1);

    // back-to-back: request on the handshake cycle's following IDLE cycle
    spawn_ready = 1'b1;
    tick();
    spawn_ready = 1'b0;
    occupied    = 16'h0000;
    rand_in     = 4'd10;
    spawn_req   = 1'b1;
    tick();
    spawn_req = 1'b0;
    check("b2b_busy", busy, 1);
    rand_in = 4'd15;
    tick();
    check("b2b_valid", spawn_valid, 1);
    check("b2b_cell",  spawn_cell,  10);
    check("b2b_value", spawn_value, 1);

    // async reset while presenting
    #2 reset = 1'b1;
    #1;
    check("t1_valid", spawn_valid, 0);
    check("t1_cell",  spawn_cell,  0);
    check("t1_value", spawn_value, 0);
    check("t1_busy",  busy,        0);
    check("t1_full",  board_full,  0);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t1_post_valid", spawn_valid, 0);
      check("t1_post_busy",  busy,        0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
